// File: rtl/sprite_pkg.sv
// Build-time configuration and shared types for the sprite line evaluator.
package sprite_pkg;

    localparam int SPRITE_COUNT     = 32;
    localparam int ID_WIDTH         = 5;
    localparam int COORD_WIDTH      = 10;
    localparam int SPRITE_SIZE      = 16;
    localparam int MAX_PER_LINE     = 8;

    localparam int ROW_WIDTH        = $clog2(SPRITE_SIZE);
    localparam int SLOT_INDEX_WIDTH = $clog2(MAX_PER_LINE);
    localparam int COUNT_WIDTH      = SLOT_INDEX_WIDTH + 1;

    typedef struct packed {
        logic                   visible;
        logic [COORD_WIDTH-1:0] x;
        logic [COORD_WIDTH-1:0] y;
    } sprite_entry_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]    id;
        logic [COORD_WIDTH-1:0] x;
        logic [ROW_WIDTH-1:0]   row;
    } slot_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } eval_state_t;

endpackage

// File: rtl/sprite_hit_compare.sv
// Combinational test of one sprite entry against a scanline; yields hit flag and row.
module sprite_hit_compare
    import sprite_pkg::*;
(
    input  sprite_entry_t          entry,
    input  logic [COORD_WIDTH-1:0] line,
    output logic                   hit,
    output logic [ROW_WIDTH-1:0]   row
);

    logic [COORD_WIDTH:0] line_ext;
    logic [COORD_WIDTH:0] top_ext;
    logic [COORD_WIDTH:0] bottom_ext;

    // One extra bit keeps y + SPRITE_SIZE from wrapping near the bottom of the screen.
    assign line_ext   = {1'b0, line};
    assign top_ext    = {1'b0, entry.y};
    assign bottom_ext = top_ext + (COORD_WIDTH+1)'(SPRITE_SIZE);

    assign hit = entry.visible && (line_ext >= top_ext) && (line_ext < bottom_ext);
    assign row = ROW_WIDTH'(line - entry.y);

endmodule

// File: rtl/sprite_line_evaluator.sv
// Shadow/active sprite tables with vsync commit, plus a per-line scan that fills
// up to MAX_PER_LINE slots in ascending id order for the pixel renderer.
module sprite_line_evaluator
    import sprite_pkg::*;
(
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        write_valid,
    input  logic [ID_WIDTH-1:0]         write_id,
    input  logic [COORD_WIDTH-1:0]      write_x,
    input  logic [COORD_WIDTH-1:0]      write_y,
    input  logic                        write_visible,
    input  logic                        vsync_pulse,
    input  logic                        line_start,
    input  logic [COORD_WIDTH-1:0]      line_number,
    input  logic [SLOT_INDEX_WIDTH-1:0] slot_index,
    output logic [ID_WIDTH-1:0]         slot_id,
    output logic [COORD_WIDTH-1:0]      slot_x,
    output logic [ROW_WIDTH-1:0]        slot_row,
    output logic [COUNT_WIDTH-1:0]      slot_count,
    output logic                        overflow,
    output logic                        eval_busy,
    output logic                        eval_done
);

    sprite_entry_t             shadow_reg  [SPRITE_COUNT];
    sprite_entry_t             shadow_next [SPRITE_COUNT];
    sprite_entry_t             active_reg  [SPRITE_COUNT];
    slot_t                     slot_reg    [MAX_PER_LINE];

    eval_state_t               state_reg;
    eval_state_t               state_next;
    logic [COORD_WIDTH-1:0]    line_reg;
    logic [ID_WIDTH-1:0]       index_reg;
    logic [COUNT_WIDTH-1:0]    hit_count_reg;
    logic [COUNT_WIDTH-1:0]    slot_count_reg;
    logic                      overflow_reg;
    logic                      commit_pending_reg;

    sprite_entry_t             scan_entry;
    logic                      scan_hit;
    logic [ROW_WIDTH-1:0]      scan_row;
    logic                      slots_full;
    logic                      scan_last;
    logic                      slot_write;
    logic                      scan_overflow;
    logic                      publish;
    logic                      do_commit;
    slot_t                     slot_read;

    // Same-cycle write is folded in here so a coincident vsync commits it too.
    genvar gi;
    generate
        for (gi = 0; gi < SPRITE_COUNT; gi++) begin : g_shadow
            assign shadow_next[gi] = (write_valid && (write_id == ID_WIDTH'(gi)))
                                   ? {write_visible, write_x, write_y}
                                   : shadow_reg[gi];
        end
    endgenerate

    assign scan_entry = active_reg[index_reg];

    sprite_hit_compare u_hit_compare (
        .entry (scan_entry),
        .line  (line_reg),
        .hit   (scan_hit),
        .row   (scan_row)
    );

    assign slots_full = (hit_count_reg == COUNT_WIDTH'(MAX_PER_LINE));
    assign scan_last  = (index_reg == ID_WIDTH'(SPRITE_COUNT - 1));
    assign publish    = (state_reg == ST_SCAN) && (state_next == ST_DONE);

    always_comb begin
        state_next    = state_reg;
        eval_busy     = 1'b0;
        eval_done     = 1'b0;
        slot_write    = 1'b0;
        scan_overflow = 1'b0;
        do_commit     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                do_commit = vsync_pulse || commit_pending_reg;
                if (line_start) begin
                    state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                eval_busy = 1'b1;
                if (scan_last) begin
                    state_next = ST_DONE;
                end
                if (scan_hit) begin
                    if (slots_full) begin
                        scan_overflow = 1'b1;
                        state_next    = ST_DONE;
                    end else begin
                        slot_write = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                eval_busy  = 1'b1;
                eval_done  = 1'b1;
                do_commit  = vsync_pulse || commit_pending_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shadow_reg <= '{default: '0};
            active_reg <= '{default: '0};
        end else begin
            shadow_reg <= shadow_next;
            if (do_commit) begin
                active_reg <= shadow_next;
            end
        end
    end

    // Results are published on the edge into DONE so they are already valid while eval_done is high.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg          <= ST_IDLE;
            line_reg           <= '0;
            index_reg          <= '0;
            hit_count_reg      <= '0;
            slot_count_reg     <= '0;
            overflow_reg       <= 1'b0;
            commit_pending_reg <= 1'b0;
            slot_reg           <= '{default: '0};
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && line_start) begin
                line_reg      <= line_number;
                index_reg     <= '0;
                hit_count_reg <= '0;
            end
            if (state_reg == ST_SCAN) begin
                index_reg <= index_reg + 1'b1;
            end
            if (slot_write) begin
                slot_reg[hit_count_reg[SLOT_INDEX_WIDTH-1:0]] <= {index_reg, scan_entry.x, scan_row};
                hit_count_reg <= hit_count_reg + 1'b1;
            end
            if (publish) begin
                slot_count_reg <= slot_write ? (hit_count_reg + 1'b1) : hit_count_reg;
                overflow_reg   <= scan_overflow;
            end
            if (do_commit) begin
                commit_pending_reg <= 1'b0;
            end else if (vsync_pulse && eval_busy) begin
                commit_pending_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        slot_read = '0;
        if ({1'b0, slot_index} < slot_count_reg) begin
            slot_read = slot_reg[slot_index];
        end
    end

    assign slot_id    = slot_read.id;
    assign slot_x     = slot_read.x;
    assign slot_row   = slot_read.row;
    assign slot_count = slot_count_reg;
    assign overflow   = overflow_reg;

endmodule

// File: doc/sprite_line_evaluator.md
# sprite_line_evaluator

Sprite attribute store and per-scanline evaluator that sits directly downstream of the game processor. It takes the processor's sprite position writes (`sprite_id`, `sprite_x`, `sprite_y`) into a shadow table and commits them to an active table at vertical sync. During each horizontal blank it scans the active table and builds a list of up to `MAX_PER_LINE` sprites that intersect the next scanline, for the pixel renderer to read.

## Interface
- `SPRITE_COUNT`, 32: table entries; must equal 2^ID_WIDTH.
- `ID_WIDTH`, 5: sprite id width, matches processor `sprite_id`.
- `COORD_WIDTH`, 10: coordinate width, matches processor `sprite_x`/`sprite_y`.
- `SPRITE_SIZE`, 16: sprite height in lines; power of two.
- `MAX_PER_LINE`, 8: slot capacity per line; power of two.

Ports:
- `clock`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high.
- `write_valid`  in  1  one-cycle strobe; write shadow entry.
- `write_id`  in  ID_WIDTH  entry index.
- `write_x`  in  COORD_WIDTH  sprite left x.
- `write_y`  in  COORD_WIDTH  sprite top y.
- `write_visible`  in  1  entry visible flag.
- `vsync_pulse`  in  1  one-cycle pulse; commit shadow to active.
- `line_start`  in  1  one-cycle pulse; begin evaluation.
- `line_number`  in  COORD_WIDTH  line to evaluate; sampled with `line_start`.
- `slot_index`  in  log2(MAX_PER_LINE)  slot read address.
- `slot_id`  out  ID_WIDTH  id in addressed slot.
- `slot_x`  out  COORD_WIDTH  x in addressed slot.
- `slot_row`  out  log2(SPRITE_SIZE)  row within sprite (`line - y`).
- `slot_count`  out  log2(MAX_PER_LINE)+1  valid slots, from 0 to MAX_PER_LINE.
- `overflow`  out  1  more than MAX_PER_LINE hits on the last line.
- `eval_busy`  out  1  scan in progress.
- `eval_done`  out  1  one-cycle pulse when the result is valid.

## Operation
- Shadow write: when `write_valid` is high, the shadow entry `write_id` gets {visible, x, y} at the next edge. Last write wins.
- Commit: `vsync_pulse` copies all shadow entries to active in one cycle.
  - A write in the same cycle is included in that commit.
  - A pulse that arrives while `eval_busy` is high sets `commit_pending`. The copy then happens in the DONE cycle.
- FSM states: IDLE, SCAN, DONE.
  - IDLE + `line_start`: latch `line_number`. Set index=0, hit_count=0, ovf=0. Go to SCAN.
  - SCAN: examine active[index] once per cycle.
    - Hit condition: visible && `line >= y` && `line < y + SPRITE_SIZE`. The sum is computed at COORD_WIDTH+1 bits, so there is no wrap.
    - On a hit with hit_count < MAX: write slot[hit_count] = {index, x, line - y (low bits)}, then increment hit_count.
    - On a hit with hit_count == MAX: set ovf and go to DONE immediately.
    - Otherwise: after index == SPRITE_COUNT-1, go to DONE.
  - DONE (one cycle): pulse `eval_done`. Publish `slot_count` = hit_count and `overflow` = ovf. Apply any pending commit. Return to IDLE.
- Priority: a lower id occupies a lower slot and wins on overflow.
- `line_start` while not IDLE is ignored. It is not queued.
- Slot read is combinational from slot registers.
  - For `slot_index >= slot_count`, all slot outputs read 0.
  - Slots being rewritten during SCAN are not guaranteed stable. Consumers read only between `eval_done` and the next `line_start`.

## Timing
- `line_start` at cycle T starts SCAN at T+1.
- Full scan: `eval_done` at T+1+SPRITE_COUNT (T+33 by default).
- Overflow scan: `eval_done` one cycle after the (MAX+1)-th hit.
- `eval_busy` is high from T+1 through the DONE cycle inclusive.
- A write is visible in shadow one cycle later. It is visible in active one cycle after commit.
- Reset values:
  - All shadow and active entries: visible=0, x=0, y=0.
  - All slots 0; `slot_count`=0, `overflow`=0.
  - `eval_busy`=0, `eval_done`=0, `commit_pending`=0. FSM in IDLE.
- Reset mid-scan aborts the scan with no `eval_done`.

## Structure
- Package `sprite_pkg` holds:
  - the parameters' default constants;
  - a `sprite_entry_t` typedef {visible, x, y};
  - a `slot_t` typedef {id, x, row};
  - the FSM state enum.
- One sub-module, `sprite_hit_compare`: combinational. Takes entry and line; returns hit and row, with the width rules above.

## Test plan
- Write id 3 {vis=1, x=100, y=50}, then `vsync_pulse`, then `line_start` with line=55.
  - Required: `eval_done` 33 cycles later; `slot_count`=1; slot0 = {3, 100, 5}; `overflow`=0.
- Boundary lines, with y=50:
  - line 49 → count 0.
  - line 65 → hit, row 15.
  - line 66 → count 0.
  - y=1020 with line 1023 → hit, row 3 (no wrap).
- Ten visible sprites, ids 0..9, all with y=0; line 0.
  - Required: count 8, ids 0..7 in slots 0..7, `overflow`=1.
  - `eval_done` 10 cycles after `line_start`.
- Write id 3 without a vsync, then evaluate.
  - Required: old active values used; shadow write not visible.
- `vsync_pulse` at scan cycle 10.
  - Required: current scan uses the old table; the commit applies at DONE; the next scan sees new values.
- Assert `reset` at scan cycle 5.
  - Required: no `eval_done`; all outputs at reset values the next cycle; a subsequent `line_start` is accepted.
